// File: rtl/func_as_pkg.sv
// func_as_pkg: shared width, op encoding and strobe priority encoder for func_as.
package func_as_pkg;
    localparam int WIDTH = 4;
    typedef enum logic [1:0] {OP_PASS, OP_INC, OP_SUB, OP_ADD} op_e;
    function automatic op_e prio_op(input logic add, input logic sub, input logic inc);
        return add ? OP_ADD : sub ? OP_SUB : inc ? OP_INC : OP_PASS;
    endfunction
endpackage

// File: rtl/func_as_alu.sv
// func_as_alu: combinational modulo-16 add/sub/increment/pass on the swapped operands.
module func_as_alu
    import func_as_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_e              op,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = op == OP_ADD ? x + y :
                 op == OP_SUB ? x - y :
                 op == OP_INC ? x + WIDTH'(1) : x;
    end
endmodule

// File: rtl/func_as.sv
// func_as: registered 4-bit add/sub/inc unit with operand swap and strobe priority.
module func_as
    import func_as_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Add,
    input  logic             Sub,
    input  logic             Inc,
    input  logic             Switch,
    output logic [WIDTH-1:0] c
);
    logic [WIDTH-1:0] x, y, c_d, c_q;
    op_e op;
    always_comb begin
        x  = Switch ? a : b;
        y  = Switch ? b : a;
        op = prio_op(Add, Sub, Inc);
    end
    func_as_alu u_alu (.x(x), .y(y), .op(op), .result(c_d));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_q <= '0;
        else        c_q <= c_d;
    end
    assign c = c_q;
endmodule

// File: tb/tb_func_as.sv
// tb_func_as: directed test-plan cases plus randomized checks against an arithmetic model.
module tb_func_as;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic [3:0] a = '0, b = '0, c;
    logic       add = 1'b0, sub = 1'b0, inc = 1'b0, sw = 1'b0;
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    func_as dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .Add(add), .Sub(sub),
                 .Inc(inc), .Switch(sw), .c(c));

    function automatic logic [3:0] ref_c(int av, int bv, int ad, int su, int in, int s);
        int x, y, r;
        x = s != 0 ? av : bv;
        y = s != 0 ? bv : av;
        if (ad != 0)      r = (x + y) % 16;
        else if (su != 0) r = (x - y + 16) % 16;
        else if (in != 0) r = (x + 1) % 16;
        else              r = x;
        return 4'(r);
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int av, input int bv, input int ad, input int su,
                         input int in, input int s);
        @(negedge clk);
        a = 4'(av); b = 4'(bv); add = ad != 0; sub = su != 0; inc = in != 0; sw = s != 0;
    endtask

    task automatic step(input string tag, input int av, input int bv, input int ad,
                        input int su, input int in, input int s, input logic [3:0] exp);
        drive(av, bv, ad, su, in, s);
        @(posedge clk);
        #1;
        check(tag, c, exp);
    endtask

    initial begin
        int av, bv, ad, su, in, s;
        #2;
        a = 4'($urandom); b = 4'($urandom); add = 1'b1; sw = 1'b1;
        rst_n = 1'b0;
        #1 check("async_reset", c, 4'd0);
        repeat (2) @(posedge clk);
        #1 check("reset_held", c, 4'd0);
        @(negedge clk) rst_n = 1'b1;
        step("first_add", 9, 2, 1, 0, 0, 1, 4'd11);
        step("sw1_sub",   9, 2, 0, 1, 0, 1, 4'd7);
        step("sw1_pass",  9, 2, 0, 0, 0, 1, 4'd9);
        step("sw1_inc",   9, 2, 0, 0, 1, 1, 4'd10);
        step("sw0_add",   9, 2, 1, 0, 0, 0, 4'd11);
        step("sw0_sub",   9, 2, 0, 1, 0, 0, 4'd9);
        step("sw0_pass",  9, 2, 0, 0, 0, 0, 4'd2);
        step("sw0_inc",   9, 2, 0, 0, 1, 0, 4'd3);
        step("wrap_inc", 15, 0, 0, 0, 1, 1, 4'd0);
        step("wrap_add", 15, 1, 1, 0, 0, 1, 4'd0);
        step("wrap_sub",  0, 1, 0, 1, 0, 1, 4'd15);
        step("prio_all",  9, 2, 1, 1, 1, 1, 4'd11);
        step("prio_si",   9, 2, 0, 1, 1, 1, 4'd7);
        drive(9, 2, 0, 0, 1, 1);
        #2 check("hold_mid_cycle", c, 4'd7);
        @(posedge clk);
        #1 check("hold_update", c, 4'd10);
        @(negedge clk) rst_n = 1'b0;
        #1 check("mid_reset", c, 4'd0);
        @(posedge clk);
        #1 check("mid_reset_held", c, 4'd0);
        @(negedge clk) rst_n = 1'b1;
        step("after_reset", 9, 2, 0, 1, 0, 1, 4'd7);
        for (int i = 0; i < 300; i++) begin
            av = int'($urandom_range(15)); bv = int'($urandom_range(15));
            ad = int'($urandom_range(1));  su = int'($urandom_range(1));
            in = int'($urandom_range(1));  s  = int'($urandom_range(1));
            step("random", av, bv, ad, su, in, s, ref_c(av, bv, ad, su, in, s));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
